// File: rtl/wash_setup.sv
// rtl/wash_setup.sv - wash mode, balance and price capture stage ahead of billing
module wash_setup #(
    parameter int BLINK_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        btn_ok,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        sw_admin,
    output logic [1:0]  mode,
    output logic [11:0] bal,
    output logic [11:0] set0,
    output logic [11:0] set1,
    output logic [11:0] set2,
    output logic [11:0] set3,
    output logic [11:0] setfine,
    output logic [11:0] price,
    output logic        start,
    output logic        ready,
    output logic [15:0] disp
);

    typedef enum logic [1:0] {S_MODE, S_BAL, S_PRICE, S_READY} state_t;

    localparam int CW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYC - 1);

    state_t        state, state_nx;
    logic [1:0]    mode_nx;
    logic [11:0]   bal_nx;
    logic [11:0]   setv [0:4];
    logic [11:0]   setv_nx [0:4];
    logic [1:0]    cursor, cursor_nx;
    logic [2:0]    field, field_nx;
    logic [CW-1:0] blink_cnt, blink_cnt_nx;
    logic          blink_vis, blink_vis_nx;
    logic          start_nx, ready_nx;
    logic [15:0]   disp_nx;
    logic          act;

    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic up);
        if (up)
            return (d >= 4'd9) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    // Edits one BCD digit in place; neighbours never see a carry or borrow.
    function automatic logic [11:0] bcd_edit(input logic [11:0] v, input logic [1:0] cur,
                                             input logic up);
        logic [11:0] r;
        r = v;
        case (cur)
            2'd0:    r[3:0]  = digit_step(v[3:0], up);
            2'd1:    r[7:4]  = digit_step(v[7:4], up);
            default: r[11:8] = digit_step(v[11:8], up);
        endcase
        return r;
    endfunction

    always_comb begin
        state_nx     = state;
        mode_nx      = mode;
        bal_nx       = bal;
        setv_nx      = setv;
        cursor_nx    = cursor;
        field_nx     = field;
        blink_cnt_nx = blink_cnt;
        blink_vis_nx = blink_vis;
        act          = 1'b0;
        disp_nx      = 16'h0000;

        if (!on) begin
            state_nx  = S_MODE;
            cursor_nx = 2'd0;
            field_nx  = 3'd0;
        end else begin
            case (state)
                S_MODE: begin
                    if (btn_ok) begin
                        state_nx  = S_BAL;
                        cursor_nx = 2'd0;
                    end else if (btn_next) begin
                        if (sw_admin) begin
                            state_nx  = S_PRICE;
                            field_nx  = 3'd0;
                            cursor_nx = 2'd0;
                        end
                    end else if (btn_inc) begin
                        mode_nx = mode + 2'd1;
                    end else if (btn_dec) begin
                        mode_nx = mode - 2'd1;
                    end
                end
                S_BAL: begin
                    act = btn_ok | btn_next | btn_inc | btn_dec;
                    if (btn_ok)
                        state_nx = S_READY;
                    else if (btn_next)
                        cursor_nx = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
                    else if (btn_inc)
                        bal_nx = bcd_edit(bal, cursor, 1'b1);
                    else if (btn_dec)
                        bal_nx = bcd_edit(bal, cursor, 1'b0);
                end
                S_PRICE: begin
                    if (!sw_admin) begin
                        state_nx  = S_MODE;
                        field_nx  = 3'd0;
                        cursor_nx = 2'd0;
                    end else begin
                        act = btn_ok | btn_next | btn_inc | btn_dec;
                        if (btn_ok) begin
                            cursor_nx = 2'd0;
                            if (field == 3'd4) begin
                                state_nx = S_MODE;
                                field_nx = 3'd0;
                            end else begin
                                field_nx = field + 3'd1;
                            end
                        end else if (btn_next) begin
                            cursor_nx = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
                        end else if (btn_inc) begin
                            setv_nx[field] = bcd_edit(setv[field], cursor, 1'b1);
                        end else if (btn_dec) begin
                            setv_nx[field] = bcd_edit(setv[field], cursor, 1'b0);
                        end
                    end
                end
                default: ;
            endcase
        end

        // Blink restarts visible whenever the operator does something or the state moves.
        if (state_nx != state || act || !(state_nx == S_BAL || state_nx == S_PRICE)) begin
            blink_cnt_nx = '0;
            blink_vis_nx = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nx = '0;
            blink_vis_nx = ~blink_vis;
        end else begin
            blink_cnt_nx = blink_cnt + CW'(1);
        end

        start_nx = (state_nx == S_READY) && (state != S_READY);
        ready_nx = (state_nx == S_READY);

        case (state_nx)
            S_MODE:  disp_nx = {2'b00, mode_nx, setv_nx[mode_nx]};
            S_BAL:   disp_nx = {4'd11, bal_nx};
            S_PRICE: disp_nx = {1'b0, field_nx, setv_nx[field_nx]};
            default: disp_nx = {4'd10, bal_nx};
        endcase

        if (!blink_vis_nx && (state_nx == S_BAL || state_nx == S_PRICE)) begin
            case (cursor_nx)
                2'd0:    disp_nx[3:0]  = 4'd11;
                2'd1:    disp_nx[7:4]  = 4'd11;
                default: disp_nx[11:8] = 4'd11;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_MODE;
            mode      <= 2'd1;
            bal       <= 12'h196;
            setv[0]   <= 12'h023;
            setv[1]   <= 12'h045;
            setv[2]   <= 12'h067;
            setv[3]   <= 12'h089;
            setv[4]   <= 12'h028;
            cursor    <= 2'd0;
            field     <= 3'd0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
            start     <= 1'b0;
            ready     <= 1'b0;
            disp      <= 16'h1045;
        end else begin
            state     <= state_nx;
            mode      <= mode_nx;
            bal       <= bal_nx;
            setv      <= setv_nx;
            cursor    <= cursor_nx;
            field     <= field_nx;
            blink_cnt <= blink_cnt_nx;
            blink_vis <= blink_vis_nx;
            start     <= start_nx;
            ready     <= ready_nx;
            disp      <= disp_nx;
        end
    end

    assign set0    = setv[0];
    assign set1    = setv[1];
    assign set2    = setv[2];
    assign set3    = setv[3];
    assign setfine = setv[4];
    assign price   = setv[mode];

endmodule

// File: doc/wash_setup.md
# wash_setup

Front-end configuration stage for the washing-machine controller, directly upstream of the billing stage. From single-cycle button pulses it captures the wash mode and the customer balance, and in admin mode lets an operator edit the four mode prices and the idle-run fine. All values are held as 3-digit BCD and presented as stable registered outputs. A one-cycle `start` pulse hands the configuration to billing. A 4-digit code word drives the shared 4-digit scanner.

## Interface
- `BLINK_CYC`, default 50_000_000: clock cycles per half-period of the cursor-digit blink.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `on` in 1: machine enable, level. Low forces the block to S_MODE.
- `btn_ok`, `btn_next`, `btn_inc`, `btn_dec` in 1 each: debounced single-cycle pulses from the button stage.
- `sw_admin` in 1: admin switch, level.
- `mode` out 2: 0 = spin, 1 = small, 2 = medium, 3 = large.
- `bal` out 12: customer balance, BCD {hundreds, tens, units}.
- `set0`, `set1`, `set2`, `set3` out 12 each: per-mode prices, BCD.
- `setfine` out 12: idle-run fine, BCD.
- `price` out 12: the `setN` selected by the current `mode`, combinational mux of registered values.
- `start` out 1: one-cycle pulse on entry to S_READY.
- `ready` out 1: high while in S_READY.
- `disp` out 16: four digit codes {d3, d2, d1, d0}, d3 leftmost. Codes 0–9 are digits, 10 is "-", 11 is blank.

## Operation
- States: S_MODE, S_BAL, S_PRICE, S_READY. State register reset value is S_MODE.
- Reset values:
  - `mode`=1, `bal`=196, `set0`=023, `set1`=045, `set2`=067, `set3`=089, `setfine`=028.
  - `start`=0, `ready`=0, cursor=0, field=0, blink phase=visible, blink counter=0.
- Cursor (0 = units, 1 = tens, 2 = hundreds) selects the BCD digit being edited.
- Field (0–3 = `set0`–`set3`, 4 = `setfine`) selects the value edited in S_PRICE.
- Pulse priority when several arrive in the same cycle: `btn_ok` > `btn_next` > `btn_inc` > `btn_dec`. Only the highest-priority pulse acts.
- S_MODE:
  - inc: `mode`+1, wrapping 3→0.
  - dec: `mode`−1, wrapping 0→3.
  - ok: go to S_BAL with cursor=0.
  - next with `sw_admin`=1: go to S_PRICE with field=0, cursor=0.
  - next with `sw_admin`=0: ignored.
  - `disp` = {`mode`, `price`}.
- S_BAL:
  - next: cursor+1, wrapping 2→0.
  - inc/dec: change the cursor digit by ±1 with per-digit wrap (9→0, 0→9) and no carry or borrow into neighbouring digits.
  - ok: go to S_READY.
  - `disp` = {11, `bal`}.
- S_PRICE:
  - next, inc, dec: same digit editing as S_BAL, applied to the selected field.
  - ok with field<4: field+1, cursor=0.
  - ok with field=4: go to S_MODE, field=0.
  - `sw_admin` falling low: go to S_MODE immediately. Edits already made are kept.
  - `disp` = {field, selected value}.
- S_READY:
  - All configuration outputs frozen. Every button is ignored.
  - Stays in S_READY while `on`=1.
  - `disp` = {10, `bal`}.
- `on`=0 in any state: go to S_MODE next cycle. `ready` and `start` drop, cursor and field clear. `mode`, `bal` and prices are kept.
- Blink:
  - A counter runs only in S_BAL and S_PRICE. It clears on every state change and on every button action.
  - At `BLINK_CYC`−1 it wraps and toggles the blink phase.
  - In the hidden phase, the cursor digit's code in `disp` is replaced by 11.

## Timing
- All outputs are registered except `price` (combinational mux of registered values).
- A button pulse at cycle N produces the updated value, state and `disp` at cycle N+1.
- `start` is high for exactly cycle N+1 after the `btn_ok` pulse that leaves S_BAL. `ready` rises in the same cycle and holds.
- An asynchronous `rst` assertion in any state, including S_READY mid-hand-off, immediately restores all reset values. `start` is never left high.
- BCD digits never hold 10–15; editing keeps every nibble in 0–9.
- Blink phase visible→hidden after `BLINK_CYC` cycles without a button action.

## Test plan
- Reset with no buttons → `mode`=1, `bal`=196, `set1`=045, `price`=045, `disp`={1,0,4,5}, `ready`=0.
- S_MODE: inc ×3 → `mode` sequence 2,3,0, with `price` following 067, 089, 023. Then dec → `mode`=3.
- S_BAL from 196: inc (units→7); next, inc ×4 (tens 9→0→1→2→3); next, dec ×2 (hundreds 1→0→9); ok → `bal`=937. `start` high exactly one cycle, `ready`=1. Buttons in S_READY leave `bal` unchanged.
- Admin: `sw_admin`=1, next, inc on field 0 → `set0`=024. Then ok ×4 (fields 1–4), inc on field 4 → `setfine`=029. Then ok → S_MODE.
- Simultaneous `btn_ok`+`btn_inc` in S_BAL → state goes to S_READY and `bal` is unchanged. `on` dropped in S_READY → S_MODE next cycle with `ready`=0.
- Blink with `BLINK_CYC`=4 in S_BAL, cursor=1 → `disp` d1 alternates 9 / 11 every 4 cycles. An inc pulse restarts the counter with the digit visible.
